// File: rtl/hp_sensor_array_if.sv
// hp_sensor_array_if: control/status bundle for hp_sensor_array.
// GLITCH exists only when HP_GLITCH_INJECT_EN is defined.
interface hp_sensor_array_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W = 16
);
   logic EN;
   logic CLR;
   logic [CHANNELS-1:0] VCC;
   logic ALARM;
   logic [CHANNELS-1:0] ALARM_VEC;
   logic [CNT_W-1:0] TRIP_COUNT;
   logic [1:0] STATE;
`ifdef HP_GLITCH_INJECT_EN
   logic [CHANNELS-1:0] GLITCH;
   modport master (output EN, CLR, VCC, GLITCH, input ALARM, ALARM_VEC, TRIP_COUNT, STATE);
   modport slave (input EN, CLR, VCC, GLITCH, output ALARM, ALARM_VEC, TRIP_COUNT, STATE);
`else
   modport master (output EN, CLR, VCC, input ALARM, ALARM_VEC, TRIP_COUNT, STATE);
   modport slave (input EN, CLR, VCC, output ALARM, ALARM_VEC, TRIP_COUNT, STATE);
`endif
endinterface

// File: rtl/hp_sensor_array.sv
// hp_sensor_array: multi-channel phase-toggle glitch sensor bank with arming FSM and trip counter.
// Defining HP_GLITCH_INJECT_EN adds the per-channel GLITCH XOR on each oscillator output.
module hp_sensor_array #(
   parameter int CHANNELS = 4,
   parameter bit INVERT = 1'b0,
   parameter int THRESH = 2,
   parameter int WARMUP = 4,
   parameter int CNT_W = 16
) (
   input logic CK,
   input logic RST,
   hp_sensor_array_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_MONITOR, S_TRIPPED} state_t;
   localparam int RW = $clog2(THRESH + 1);
   localparam int WW = $clog2(WARMUP + 1);
   localparam logic [RW-1:0] TH = RW'(THRESH);
   localparam logic [RW-1:0] TH_M1 = RW'(THRESH - 1);
   localparam logic [WW-1:0] WU_M1 = WW'(WARMUP - 1);
   state_t state_q, state_d;
   logic p_q, p_d, cap, watch;
   logic [CHANNELS-1:0] d_q, d_d, b_q, b_d, a_q, a_d, alarm_q, alarm_d, o, raw, trip;
   logic [CHANNELS-1:0][RW-1:0] run_q, run_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef HP_GLITCH_INJECT_EN
   assign o = d_q ^ bus.GLITCH;
`else
   assign o = d_q;
`endif
   // a healthy oscillator never shows the same value in all three taps
   assign raw = ~(o ^ b_q) & ~(b_q ^ a_q);
   assign watch = state_q == S_MONITOR || state_q == S_TRIPPED;
   assign cap = p_q == INVERT;
   always_comb begin
      p_d = ~p_q;
      d_d = cap ? bus.VCC & ~d_q : d_q;
      b_d = cap ? o : b_q;
      a_d = cap ? a_q : b_q;
      for (int i = 0; i < CHANNELS; i++) begin
         trip[i] = watch && raw[i] && run_q[i] >= TH_M1;
         run_d[i] = (bus.CLR || !watch || !raw[i]) ? '0 : (run_q[i] == TH ? TH : run_q[i] + RW'(1));
      end
      alarm_d = bus.CLR ? '0 : alarm_q | trip;
      cnt_d = bus.CLR ? '0 : (|(trip & ~alarm_q) && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
      wcnt_d = (state_q == S_WARMUP && bus.EN && !bus.CLR) ? wcnt_q + WW'(1) : '0;
      state_d = state_q;
      if (bus.CLR) state_d = bus.EN ? S_WARMUP : S_IDLE;
      else if (!bus.EN) state_d = S_IDLE;
      else if (state_q == S_IDLE) state_d = S_WARMUP;
      else if (state_q == S_WARMUP && wcnt_q == WU_M1) state_d = S_MONITOR;
      else if (state_q == S_MONITOR && |trip) state_d = S_TRIPPED;
   end
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q <= S_IDLE;
         p_q <= 1'b0;
         d_q <= '0;
         b_q <= '0;
         a_q <= '0;
         run_q <= '0;
         wcnt_q <= '0;
         alarm_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         p_q <= p_d;
         d_q <= d_d;
         b_q <= b_d;
         a_q <= a_d;
         run_q <= run_d;
         wcnt_q <= wcnt_d;
         alarm_q <= alarm_d;
         cnt_q <= cnt_d;
      end
   end
   assign bus.ALARM = |alarm_q;
   assign bus.ALARM_VEC = alarm_q;
   assign bus.TRIP_COUNT = cnt_q;
   assign bus.STATE = state_q;
endmodule
